dec_bin100: RTL and testbench



---
 rtl/dec_bin100.sv | 117 +++++++++++
 tb/tb_dec_bin100.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dec_bin100.sv
`default_nettype none
// dec_bin100: sequential three-digit BCD to 10-bit binary converter.
// One digit is folded in per clock as acc*10 + digit; digits above 9 are rejected.
module dec_bin100 (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [3:0] DEC_IN2,
  input  logic [3:0] DEC_IN1,
  input  logic [3:0] DEC_IN0,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [9:0] BIN_OUT2
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t     state_q;
  logic [1:0] step_q;
  logic [9:0] acc_q;
  logic [9:0] acc_d;
  logic [3:0] dig2_q;
  logic [3:0] dig1_q;
  logic [3:0] dig0_q;
  logic [3:0] dig_sel;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [9:0] bin_q;
  logic       bad_digit;

  // Hundreds first, so three multiply-accumulate steps yield the full value.
  always_comb begin
    dig_sel = dig0_q;
    case (step_q)
      2'd0:    dig_sel = dig2_q;
      2'd1:    dig_sel = dig1_q;
      default: dig_sel = dig0_q;
    endcase
  end

  // Largest intermediate is 99*10+9 = 999, which fits in 10 bits.
  assign acc_d = (acc_q << 3) + (acc_q << 1) + {6'd0, dig_sel};

  assign bad_digit = (DEC_IN2 > 4'd9) || (DEC_IN1 > 4'd9) || (DEC_IN0 > 4'd9);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      acc_q   <= 10'd0;
      dig2_q  <= 4'd0;
      dig1_q  <= 4'd0;
      dig0_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= 10'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            dig2_q <= DEC_IN2;
            dig1_q <= DEC_IN1;
            dig0_q <= DEC_IN0;
            if (bad_digit) begin
              err_q   <= 1'b1;
              bin_q   <= 10'd0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              err_q   <= 1'b0;
              acc_q   <= 10'd0;
              step_q  <= 2'd0;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (step_q == 2'd2) begin
            bin_q   <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            step_q  <= 2'd0;
            state_q <= S_FIN;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign BIN_OUT2 = bin_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_bin100.sv
`default_nettype none
// tb_dec_bin100: directed tests for dec_bin100 with a per-cycle reference model.
module tb_dec_bin100;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic [3:0] DEC_IN2 = 4'd0;
  logic [3:0] DEC_IN1 = 4'd0;
  logic [3:0] DEC_IN0 = 4'd0;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [9:0] BIN_OUT2;

  int n_checks = 0;
  int n_pass   = 0;

  dec_bin100 dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .DEC_IN2  (DEC_IN2),
    .DEC_IN1  (DEC_IN1),
    .DEC_IN0  (DEC_IN0),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .BIN_OUT2 (BIN_OUT2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a request is either rejected immediately, or finishes
  // three edges later with the decimal value; DONE lasts one cycle and the
  // block is available again on the edge after DONE.
  int m_busy = 0;
  int m_done = 0;
  int m_err  = 0;
  int m_bin  = 0;
  int m_left = 0;
  int m_pend = 0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_busy = 0; m_done = 0; m_err = 0; m_bin = 0; m_left = 0; m_pend = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_busy != 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_bin  = m_pend;
      end
    end else if (START) begin
      if (DEC_IN2 > 9 || DEC_IN1 > 9 || DEC_IN0 > 9) begin
        m_err = 1; m_bin = 0; m_done = 1;
      end else begin
        m_err  = 0;
        m_busy = 1;
        m_left = 3;
        m_pend = 100 * int'(DEC_IN2) + 10 * int'(DEC_IN1) + int'(DEC_IN0);
      end
    end
  end

  always @(negedge CLK) begin
    chk("model_busy", int'(BUSY), m_busy);
    chk("model_done", int'(DONE), m_done);
    chk("model_err",  int'(ERR),  m_err);
    chk("model_bin",  int'(BIN_OUT2), m_bin);
  end

  // Called at a falling edge; returns at the falling edge after DONE drops,
  // so consecutive calls run at the minimum start-to-start interval.
  task automatic do_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input int exp_bin, input int exp_err, input string tag);
    int busy_cnt;
    int lat;
    busy_cnt = 0;
    lat = 0;
    DEC_IN2 = h; DEC_IN1 = t; DEC_IN0 = o;
    START = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (BUSY) busy_cnt++;
      if (DONE) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk({tag, "_done_timeout"}, 0, 1);
    chk({tag, "_latency"}, lat, (exp_err != 0) ? 1 : 4);
    chk({tag, "_busy_cycles"}, busy_cnt, (exp_err != 0) ? 0 : 3);
    chk({tag, "_bin"}, int'(BIN_OUT2), exp_bin);
    chk({tag, "_err"}, int'(ERR), exp_err);
    @(negedge CLK);
    chk({tag, "_done_fell"}, int'(DONE), 0);
  endtask

  initial begin
    int dones;
    // Reset values
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_err",  int'(ERR), 0);
    chk("rst_bin",  int'(BIN_OUT2), 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("idle_busy", int'(BUSY), 0);
    chk("idle_done", int'(DONE), 0);
    chk("idle_bin",  int'(BIN_OUT2), 0);

    // Nominal conversions
    do_conv(4'd9, 4'd9, 4'd9, 999, 0, "c999");
    do_conv(4'd0, 4'd0, 4'd0, 0,   0, "c000");
    do_conv(4'd1, 4'd0, 4'd0, 100, 0, "c100");
    do_conv(4'd4, 4'd5, 4'd6, 456, 0, "c456");

    // Invalid digit, then recovery
    do_conv(4'd3, 4'hA, 4'd2, 0,  1, "bad");
    do_conv(4'd0, 4'd4, 4'd2, 42, 0, "c042");

    // START held and digits changed during CALC
    DEC_IN2 = 4'd1; DEC_IN1 = 4'd2; DEC_IN0 = 4'd3;
    START = 1'b1;
    @(negedge CLK);
    DEC_IN2 = 4'd7; DEC_IN1 = 4'd7; DEC_IN0 = 4'd7;
    dones = 0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("hold_bin123", int'(BIN_OUT2), 123);
    chk("hold_done123", int'(DONE), 1);
    @(negedge CLK);
    if (DONE) dones++;
    chk("hold_fin_busy", int'(BUSY), 0);
    chk("hold_one_done", dones, 1);
    @(negedge CLK);
    chk("hold_reaccept_busy", int'(BUSY), 1);
    START = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge CLK);
    chk("hold_done777", int'(DONE), 1);
    chk("hold_bin777", int'(BIN_OUT2), 777);
    @(negedge CLK);

    // Reset in the middle of a conversion
    DEC_IN2 = 4'd8; DEC_IN1 = 4'd8; DEC_IN0 = 4'd8;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(posedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_done", int'(DONE), 0);
    chk("mid_rst_err",  int'(ERR), 0);
    chk("mid_rst_bin",  int'(BIN_OUT2), 15 - 15);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    do_conv(4'd0, 4'd1, 4'd5, 15, 0, "c015");

    // Every valid digit combination, back to back
    for (int h = 0; h < 10; h++)
      for (int t = 0; t < 10; t++)
        for (int o = 0; o < 10; o++)
          do_conv(4'(h), 4'(t), 4'(o), 100 * h + 10 * t + o, 0, "sweep");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
